// File: rtl/matbi_watch_pkg.sv
// Shared limits, FSM state type and set-range helper for the matbi watch core.
package matbi_watch_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  function automatic logic time_in_range(input int sec, input int min, input int hour);
    return (sec <= SEC_MAX) && (min <= MIN_MAX) && (hour <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/matbi_watch_tick_gen.sv
// Runtime-programmable 1 Hz divider: counts 0..i_freq-1 and flags the wrap cycle combinationally.
module matbi_watch_tick_gen #(
  parameter int P_COUNT_BIT = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic                   i_clear,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  output logic                   o_tick_pulse
);

  logic [P_COUNT_BIT-1:0] r_count;
  logic                   w_freq_zero;
  logic                   w_at_end;

  assign w_freq_zero = (i_freq == '0);
  // >= rather than == so a freshly lowered i_freq wraps on the next edge
  assign w_at_end    = (r_count >= (i_freq - P_COUNT_BIT'(1)));

  assign o_tick_pulse = i_en && !i_clear && !w_freq_zero && w_at_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_freq_zero || w_at_end) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + P_COUNT_BIT'(1);
      end
    end
  end

endmodule

// File: rtl/matbi_watch_core.sv
// Watch core: FSM, validated time-set, sec/min/hour/day counters; alarm when MATBI_WATCH_ALARM_EN is defined.
//   state   | meaning
//   ST_IDLE | time holds, sets accepted
//   ST_RUN  | time advances, sets accepted
//   ST_LOAD | one cycle after an accepted set, divider held at 0
module matbi_watch_core
  import matbi_watch_pkg::*;
#(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5,
  parameter int P_DAY_BIT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_set_valid,
  output logic                   o_set_ready,
  input  logic [P_SEC_BIT-1:0]   i_set_sec,
  input  logic [P_MIN_BIT-1:0]   i_set_min,
  input  logic [P_HOUR_BIT-1:0]  i_set_hour,
  output logic                   o_set_err,
  input  logic                   i_alarm_en,
  input  logic [P_MIN_BIT-1:0]   i_alarm_min,
  input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
  input  logic                   i_alarm_clr,
  output logic                   o_tick,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic [P_DAY_BIT-1:0]   o_day,
  output logic                   o_alarm
);

  state_e                r_state;
  logic                  r_set_ready;
  logic                  r_set_err;
  logic                  r_tick;
  logic [P_SEC_BIT-1:0]  r_sec;
  logic [P_MIN_BIT-1:0]  r_min;
  logic [P_HOUR_BIT-1:0] r_hour;
  logic [P_DAY_BIT-1:0]  r_day;

  logic                  w_set_acc;
  logic                  w_set_ok;
  logic                  w_load;
  logic                  w_div_clear;
  logic                  w_wrap;
  logic [P_SEC_BIT-1:0]  w_sec_nx;
  logic [P_MIN_BIT-1:0]  w_min_nx;
  logic [P_HOUR_BIT-1:0] w_hour_nx;
  logic [P_DAY_BIT-1:0]  w_day_nx;
  logic                  w_alarm;

  assign w_set_acc = i_set_valid && r_set_ready;
  assign w_set_ok  = time_in_range(int'(i_set_sec), int'(i_set_min), int'(i_set_hour));
  assign w_load    = w_set_acc && w_set_ok;

  // An accepted set beats a coincident wrap: clearing the divider also masks its pulse
  assign w_div_clear = w_load || (r_state == ST_LOAD);

  matbi_watch_tick_gen #(
    .P_COUNT_BIT (P_COUNT_BIT)
  ) u_tick_gen (
    .clk          (clk),
    .reset        (reset),
    .i_en         (i_run_en),
    .i_clear      (w_div_clear),
    .i_freq       (i_freq),
    .o_tick_pulse (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_set_ready <= 1'b1;
      r_set_err   <= 1'b0;
    end else begin
      r_set_err <= w_set_acc && !w_set_ok;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_load) begin
            r_state     <= ST_LOAD;
            r_set_ready <= 1'b0;
          end else if (!w_set_acc) begin
            r_state     <= i_run_en ? ST_RUN : ST_IDLE;
            r_set_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state     <= i_run_en ? ST_RUN : ST_IDLE;
          r_set_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_set_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_sec_nx  = r_sec + 1'b1;
    w_min_nx  = r_min;
    w_hour_nx = r_hour;
    w_day_nx  = r_day;
    if (r_sec == P_SEC_BIT'(SEC_MAX)) begin
      w_sec_nx = '0;
      w_min_nx = r_min + 1'b1;
      if (r_min == P_MIN_BIT'(MIN_MAX)) begin
        w_min_nx  = '0;
        w_hour_nx = r_hour + 1'b1;
        if (r_hour == P_HOUR_BIT'(HOUR_MAX)) begin
          w_hour_nx = '0;
          w_day_nx  = r_day + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_day  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_load) begin
        r_sec  <= i_set_sec;
        r_min  <= i_set_min;
        r_hour <= i_set_hour;
      end else if (w_wrap) begin
        r_sec  <= w_sec_nx;
        r_min  <= w_min_nx;
        r_hour <= w_hour_nx;
        r_day  <= w_day_nx;
      end
    end
  end

`ifdef MATBI_WATCH_ALARM_EN
  logic r_alarm;
  logic w_hit_set;
  logic w_hit_tick;

  assign w_hit_set  = w_load && (i_set_sec == '0) && (i_set_min == i_alarm_min) &&
                      (i_set_hour == i_alarm_hour);
  assign w_hit_tick = w_wrap && (w_sec_nx == '0) && (w_min_nx == i_alarm_min) &&
                      (w_hour_nx == i_alarm_hour);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm <= 1'b0;
    end else if (i_alarm_en && (w_hit_set || w_hit_tick)) begin
      r_alarm <= 1'b1;
    end else if (i_alarm_clr || !i_alarm_en) begin
      r_alarm <= 1'b0;
    end
  end

  assign w_alarm = r_alarm;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{i_alarm_en, i_alarm_min, i_alarm_hour, i_alarm_clr};
  assign w_alarm        = 1'b0;
`endif

  assign o_set_ready = r_set_ready;
  assign o_set_err   = r_set_err;
  assign o_tick      = r_tick;
  assign o_sec       = r_sec;
  assign o_min       = r_min;
  assign o_hour      = r_hour;
  assign o_day       = r_day;
  assign o_alarm     = w_alarm;

endmodule
